// File: rtl/machine_timer_pkg.sv
// Shared constants and helpers for the memory-mapped RISC-V machine timer.
// Holds register offsets, CTRL bit positions, mtimecmp reset value and a byte-lane merge helper.
package machine_timer_pkg;

  localparam logic [31:0] OFFSET_MTIME          = 32'h0000_0000;
  localparam logic [31:0] OFFSET_MTIMEH         = 32'h0000_0004;
  localparam logic [31:0] OFFSET_CTRL           = 32'h0000_0008;
  localparam logic [31:0] OFFSET_STATUS         = 32'h0000_000C;
  localparam logic [31:0] OFFSET_MTIMECMP_BASE  = 32'h0000_0010;
  localparam logic [31:0] CMP_STRIDE            = 32'h0000_0008;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_DIVISOR_LSB = 8;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] merged;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = lanes[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Data-memory port bundle between the core (master) and the machine timer (slave).
interface machine_timer_if;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [3:0]  memory_write_sections;
  logic [31:0] read_value;
  logic        read_hit;

  modport master (
    output memory_address, memory_write_value, memory_write_sections,
    input  read_value, read_hit
  );

  modport slave (
    input  memory_address, memory_write_value, memory_write_sections,
    output read_value, read_hit
  );
endinterface

// File: rtl/machine_timer_prescaler.sv
// Divide-by-(divisor+1) tick generator feeding mtime; clear restarts the count from zero.
module timer_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tick_o = enable_i && (count_q == divisor_i);

  // next count: clear wins, wrap on tick, hold while disabled
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped 64-bit mtime with prescaler and NUM_COMPARATORS mtimecmp channels.
// Optional MACHINE_TIMER_SNAPSHOT_EN latches mtime[63:32] on MTIME-low reads for atomic 64-bit reads.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h8000_0000,
  parameter int          NUM_COMPARATORS = 1,
  parameter int          PRESCALER_WIDTH = 8
) (
  input  logic                       clk24,
  input  logic                       reset_n,
  machine_timer_if.slave             bus,
  output logic [NUM_COMPARATORS-1:0] timer_interrupt
);

  localparam int NUM_WORDS = 4 + 2 * NUM_COMPARATORS;

  logic [63:0]                mtime_q, mtime_d;
  logic                       enable_q, enable_d;
  logic [PRESCALER_WIDTH-1:0] divisor_q, divisor_d;
  logic [63:0]                cmp_q [NUM_COMPARATORS];
  logic [63:0]                cmp_d [NUM_COMPARATORS];
  logic [NUM_COMPARATORS-1:0] irq_q, irq_d;
  logic [31:0]                read_value_q;
  logic                       read_hit_q;

  logic [31:0] offs_s, word_off_s, ctrl_cur_s, rdata_s, cmp_rd_s, mtimeh_rd_s;
  logic        hit_s, wr_s, tick_s, presc_clear_s;
  logic        sel_mtime_s, sel_mtimeh_s, sel_ctrl_s, sel_status_s;
  logic [NUM_COMPARATORS-1:0] sel_cmp_lo_s, sel_cmp_hi_s;

  assign offs_s       = bus.memory_address - BASE_ADDRESS;
  assign word_off_s   = offs_s & 32'hFFFF_FFFC;
  assign hit_s        = (bus.memory_address >= BASE_ADDRESS) && (word_off_s < 32'(4 * NUM_WORDS));
  assign wr_s         = hit_s && (bus.memory_write_sections != 4'b0000);
  assign sel_mtime_s  = hit_s && (word_off_s == OFFSET_MTIME);
  assign sel_mtimeh_s = hit_s && (word_off_s == OFFSET_MTIMEH);
  assign sel_ctrl_s   = hit_s && (word_off_s == OFFSET_CTRL);
  assign sel_status_s = hit_s && (word_off_s == OFFSET_STATUS);

  // per-channel decode and OR-combined compare-register read data
  always_comb begin
    sel_cmp_lo_s = '0;
    sel_cmp_hi_s = '0;
    cmp_rd_s     = 32'h0000_0000;
    for (int i = 0; i < NUM_COMPARATORS; i++) begin
      sel_cmp_lo_s[i] = hit_s && (word_off_s == OFFSET_MTIMECMP_BASE + CMP_STRIDE * 32'(i));
      sel_cmp_hi_s[i] = hit_s && (word_off_s == OFFSET_MTIMECMP_BASE + CMP_STRIDE * 32'(i) + 32'h0000_0004);
      cmp_rd_s = cmp_rd_s | ({32{sel_cmp_lo_s[i]}} & cmp_q[i][31:0])
                          | ({32{sel_cmp_hi_s[i]}} & cmp_q[i][63:32]);
    end
  end

  // A CTRL or MTIME write restarts the prescale count
  assign presc_clear_s = wr_s && (sel_ctrl_s || sel_mtime_s || sel_mtimeh_s);

  timer_prescaler #(.WIDTH(PRESCALER_WIDTH)) u_prescaler (
    .clk_i     (clk24),
    .rst_n_i   (reset_n),
    .enable_i  (enable_q),
    .clear_i   (presc_clear_s),
    .divisor_i (divisor_q),
    .tick_o    (tick_s)
  );

  // mtime next value: a write suppresses the increment and never carries across words
  always_comb begin
    mtime_d = mtime_q;
    if (wr_s && sel_mtime_s) begin
      mtime_d[31:0] = merge_lanes(mtime_q[31:0], bus.memory_write_value, bus.memory_write_sections);
    end else if (wr_s && sel_mtimeh_s) begin
      mtime_d[63:32] = merge_lanes(mtime_q[63:32], bus.memory_write_value, bus.memory_write_sections);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  // CTRL view and byte-lane update of its enable/divisor fields
  always_comb begin
    ctrl_cur_s = 32'h0000_0000;
    ctrl_cur_s[CTRL_ENABLE_BIT] = enable_q;
    ctrl_cur_s[CTRL_DIVISOR_LSB +: PRESCALER_WIDTH] = divisor_q;
    enable_d  = enable_q;
    divisor_d = divisor_q;
    if (wr_s && sel_ctrl_s) begin
      enable_d = bus.memory_write_sections[CTRL_ENABLE_BIT / 8] ?
                 bus.memory_write_value[CTRL_ENABLE_BIT] : enable_q;
      for (int b = 0; b < PRESCALER_WIDTH; b++) begin
        divisor_d[b] = bus.memory_write_sections[(CTRL_DIVISOR_LSB + b) / 8] ?
                       bus.memory_write_value[CTRL_DIVISOR_LSB + b] : divisor_q[b];
      end
    end else begin
      enable_d  = enable_q;
      divisor_d = divisor_q;
    end
  end

  // compare registers and interrupt levels from the current register values
  always_comb begin
    for (int i = 0; i < NUM_COMPARATORS; i++) begin
      cmp_d[i] = cmp_q[i];
      irq_d[i] = (mtime_q >= cmp_q[i]);
      if (wr_s && sel_cmp_lo_s[i]) begin
        cmp_d[i][31:0] = merge_lanes(cmp_q[i][31:0], bus.memory_write_value, bus.memory_write_sections);
      end else if (wr_s && sel_cmp_hi_s[i]) begin
        cmp_d[i][63:32] = merge_lanes(cmp_q[i][63:32], bus.memory_write_value, bus.memory_write_sections);
      end else begin
        cmp_d[i] = cmp_q[i];
      end
    end
  end

`ifdef MACHINE_TIMER_SNAPSHOT_EN
  logic [31:0] snap_q;

  // latch the high word whenever the low word is read
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= 32'h0000_0000;
    end else if (sel_mtime_s && (bus.memory_write_sections == 4'b0000)) begin
      snap_q <= mtime_q[63:32];
    end else begin
      snap_q <= snap_q;
    end
  end

  assign mtimeh_rd_s = snap_q;
`else
  assign mtimeh_rd_s = mtime_q[63:32];
`endif

  // read mux for the registered read port
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_mtime_s) begin
      rdata_s = mtime_q[31:0];
    end else if (sel_mtimeh_s) begin
      rdata_s = mtimeh_rd_s;
    end else if (sel_ctrl_s) begin
      rdata_s = ctrl_cur_s;
    end else if (sel_status_s) begin
      rdata_s = 32'(irq_q);
    end else begin
      rdata_s = cmp_rd_s;
    end
  end

  // architectural state and registered outputs
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q      <= 64'd0;
      enable_q     <= 1'b1;
      divisor_q    <= '0;
      irq_q        <= '0;
      read_value_q <= 32'h0000_0000;
      read_hit_q   <= 1'b0;
      for (int i = 0; i < NUM_COMPARATORS; i++) begin
        cmp_q[i] <= MTIMECMP_RESET;
      end
    end else begin
      mtime_q      <= mtime_d;
      enable_q     <= enable_d;
      divisor_q    <= divisor_d;
      irq_q        <= irq_d;
      read_value_q <= rdata_s;
      read_hit_q   <= hit_s;
      for (int i = 0; i < NUM_COMPARATORS; i++) begin
        cmp_q[i] <= cmp_d[i];
      end
    end
  end

  assign bus.read_value  = read_value_q;
  assign bus.read_hit    = read_hit_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer with two channels; a transaction-level model predicts every cycle.
module tb_machine_timer;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NCMP = 2;

  logic            clk24   = 1'b0;
  logic            reset_n = 1'b0;
  logic [NCMP-1:0] timer_interrupt;

  machine_timer_if bus();

  machine_timer #(.BASE_ADDRESS(BASE), .NUM_COMPARATORS(NCMP), .PRESCALER_WIDTH(8)) dut (
    .clk24           (clk24),
    .reset_n         (reset_n),
    .bus             (bus),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk24 = ~clk24;

  int checks   = 0;
  int failures = 0;

  // reference model state: what software would see in each register
  logic [63:0]     m_time;
  int              m_phase;
  logic            m_en;
  logic [7:0]      m_div;
  logic [63:0]     m_cmp [NCMP];
  logic [31:0]     m_snap;
  logic [NCMP-1:0] m_irq;

  logic [31:0]     exp_rv;
  logic            exp_hit;
  logic [NCMP-1:0] exp_irq;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(16 + 8 * NCMP));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] r;
    r = 32'h0;
    if (off == 32'h0) r = m_time[31:0];
`ifdef MACHINE_TIMER_SNAPSHOT_EN
    else if (off == 32'h4) r = m_snap;
`else
    else if (off == 32'h4) r = m_time[63:32];
`endif
    else if (off == 32'h8) r = {16'h0, m_div, 7'h0, m_en};
    else if (off == 32'hC) r = 32'(m_irq);
    else begin
      for (int i = 0; i < NCMP; i++) begin
        if (off == 32'h10 + 32'(8 * i)) r = m_cmp[i][31:0];
        if (off == 32'h14 + 32'(8 * i)) r = m_cmp[i][63:32];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_time = 64'd0; m_phase = 0; m_en = 1'b1; m_div = 8'd0; m_snap = 32'h0; m_irq = '0;
    for (int i = 0; i < NCMP; i++) m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  // drive one bus cycle, predict the outputs it produces, advance the model
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off, ctrl;
    logic        hit, wr, tick;
    logic [63:0] t0;
    bus.memory_address = a; bus.memory_write_value = d; bus.memory_write_sections = s;
    hit = in_window(a);
    off = (a - BASE) & 32'hFFFF_FFFC;
    wr  = hit && (s != 4'h0);
    t0  = m_time;
    exp_hit = hit;
    exp_rv  = hit ? model_read(off) : 32'h0;
    for (int i = 0; i < NCMP; i++) exp_irq[i] = (t0 >= m_cmp[i]);
    tick = m_en && (m_phase == int'(m_div));
    if (wr && off == 32'h0) begin
      m_time[31:0] = lanes(t0[31:0], d, s); m_phase = 0;
    end else if (wr && off == 32'h4) begin
      m_time[63:32] = lanes(t0[63:32], d, s); m_phase = 0;
    end else begin
      if (tick) m_time = t0 + 64'd1;
      if (m_en) m_phase = tick ? 0 : m_phase + 1;
    end
    if (wr && off == 32'h8) begin
      ctrl = lanes({16'h0, m_div, 7'h0, m_en}, d, s);
      m_en = ctrl[0]; m_div = ctrl[15:8]; m_phase = 0;
    end
    for (int i = 0; i < NCMP; i++) begin
      if (wr && off == 32'h10 + 32'(8 * i)) m_cmp[i][31:0]  = lanes(m_cmp[i][31:0], d, s);
      if (wr && off == 32'h14 + 32'(8 * i)) m_cmp[i][63:32] = lanes(m_cmp[i][63:32], d, s);
    end
    if (hit && off == 32'h0 && s == 4'h0) m_snap = t0[63:32];
    m_irq = exp_irq;
    @(posedge clk24); #1;
  endtask

  task automatic test_reset();
    bus.memory_address = 32'h0; bus.memory_write_value = 32'h0; bus.memory_write_sections = 4'h0;
    repeat (3) @(posedge clk24);
    #1;
    checks++;
    if (bus.read_value !== 32'h0 || bus.read_hit !== 1'b0 || timer_interrupt !== '0) begin
      failures++;
      $display("FAIL reset rv=%h hit=%b irq=%b expected 0/0/0", bus.read_value, bus.read_hit, timer_interrupt);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 6; k++) begin
      step(BASE, 32'h0, 4'h0);
      checks++;
      if (bus.read_value !== exp_rv || bus.read_hit !== exp_hit || timer_interrupt !== exp_irq) begin
        failures++;
        $display("FAIL idle rv=%h/%h hit=%b/%b irq=%b/%b", bus.read_value, exp_rv, bus.read_hit, exp_hit, timer_interrupt, exp_irq);
      end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] v [16];
    logic [31:0] frozen;
    step(BASE + 32'h8, 32'h0000_0301, 4'h3);
    for (int k = 0; k < 16; k++) begin
      step(BASE, 32'h0, 4'h0);
      v[k] = bus.read_value;
      checks++;
      if (bus.read_value !== exp_rv) begin
        failures++;
        $display("FAIL presc_div3 rv=%h expected %h", bus.read_value, exp_rv);
      end
    end
    for (int k = 4; k < 12; k++) begin
      checks++;
      if (v[k + 4] - v[k] !== 32'd1) begin
        failures++;
        $display("FAIL presc_rate delta=%0d expected 1", v[k + 4] - v[k]);
      end
    end
    step(BASE + 32'h8, 32'h0, 4'h3);
    step(BASE, 32'h0, 4'h0);
    frozen = exp_rv;
    for (int k = 0; k < 100; k++) begin
      step(BASE, 32'h0, 4'h0);
      checks++;
      if (bus.read_value !== frozen || exp_rv !== frozen) begin
        failures++;
        $display("FAIL presc_frozen rv=%h expected %h", bus.read_value, frozen);
      end
    end
  endtask

  task automatic test_compare();
    logic seen1;
    seen1 = 1'b0;
    step(BASE, 32'h0, 4'hF);
    step(BASE + 32'h4, 32'h0, 4'hF);
    step(BASE + 32'h8, 32'h0000_0001, 4'h1);
    step(BASE + 32'h18, 32'd10, 4'hF);
    step(BASE + 32'h1C, 32'h0, 4'hF);
    for (int k = 0; k < 14; k++) begin
      step(BASE + 32'hC, 32'h0, 4'h0);
      seen1 = seen1 | timer_interrupt[1];
      checks++;
      if (timer_interrupt !== exp_irq || bus.read_value !== exp_rv || timer_interrupt[0] !== 1'b0) begin
        failures++;
        $display("FAIL cmp_rise irq=%b expected %b status=%h/%h", timer_interrupt, exp_irq, bus.read_value, exp_rv);
      end
    end
    checks++;
    if (seen1 !== 1'b1) begin
      failures++;
      $display("FAIL cmp_seen irq1=%b expected 1", seen1);
    end
    step(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
    step(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF);
    step(BASE + 32'hC, 32'h0, 4'h0);
    checks++;
    if (timer_interrupt !== 2'b00 || exp_irq !== 2'b00) begin
      failures++;
      $display("FAIL cmp_clear irq=%b expected 00", timer_interrupt);
    end
  endtask

  task automatic test_byte_write();
    step(BASE, 32'h1122_3344, 4'hF);
    step(BASE, 32'h0000_AA00, 4'h2);
    step(BASE, 32'h0, 4'h0);
    checks++;
    if (bus.read_value !== 32'h1122_AA44 || exp_rv !== 32'h1122_AA44) begin
      failures++;
      $display("FAIL byte_write rv=%h expected 1122aa44", bus.read_value);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0; want[3] = 32'h1;
    step(BASE + 32'h8, 32'h0000_0001, 4'h3);
    step(BASE + 32'h10, 32'h0, 4'hF);
    step(BASE + 32'h14, 32'h0, 4'hF);
    step(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
    step(BASE, 32'hFFFF_FFFE, 4'hF);
    for (int k = 0; k < 4; k++) begin
      step(BASE, 32'h0, 4'h0);
      checks++;
      if (bus.read_value !== want[k] || exp_rv !== want[k] || timer_interrupt[0] !== 1'b1) begin
        failures++;
        $display("FAIL wrap[%0d] rv=%h expected %h irq0=%b expected 1", k, bus.read_value, want[k], timer_interrupt[0]);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] want_hi;
`ifdef MACHINE_TIMER_SNAPSHOT_EN
    want_hi = 32'h1;
`else
    want_hi = 32'h2;
`endif
    step(BASE + 32'h4, 32'h0000_0001, 4'hF);
    step(BASE, 32'hFFFF_FFFF, 4'hF);
    step(BASE, 32'h0, 4'h0);
    checks++;
    if (bus.read_value !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL snap_lo rv=%h expected ffffffff", bus.read_value);
    end
    step(BASE + 32'h4, 32'h0, 4'h0);
    checks++;
    if (bus.read_value !== want_hi || exp_rv !== want_hi) begin
      failures++;
      $display("FAIL snap_hi rv=%h expected %h", bus.read_value, want_hi);
    end
  endtask

  task automatic test_window();
    logic [31:0] addrs [4];
    addrs[0] = BASE + 32'h20; addrs[1] = BASE + 32'h24; addrs[2] = BASE - 32'h4; addrs[3] = 32'h0000_0010;
    for (int k = 0; k < 4; k++) begin
      step(addrs[k], 32'h0, 4'hF);
      checks++;
      if (bus.read_hit !== 1'b0 || bus.read_value !== 32'h0) begin
        failures++;
        $display("FAIL window[%0d] hit=%b rv=%h expected 0/0", k, bus.read_hit, bus.read_value);
      end
    end
    step(BASE + 32'h14, 32'h0, 4'h0);
    checks++;
    if (bus.read_value !== exp_rv || bus.read_hit !== 1'b1) begin
      failures++;
      $display("FAIL window_cmp0h rv=%h expected %h hit=%b", bus.read_value, exp_rv, bus.read_hit);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int k = 0; k < 400; k++) begin
      a = BASE + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      d = $urandom;
      if (($urandom_range(0, 3) == 0) && (((a - BASE) & 32'hFFFF_FFFC) == 32'h8)) d[15:8] = 8'($urandom_range(0, 3));
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(a, d, s);
      checks++;
      if (bus.read_value !== exp_rv || bus.read_hit !== exp_hit || timer_interrupt !== exp_irq) begin
        failures++;
        $display("FAIL random[%0d] a=%h rv=%h/%h hit=%b/%b irq=%b/%b", k, a, bus.read_value, exp_rv, bus.read_hit, exp_hit, timer_interrupt, exp_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_prescaler();
    test_compare();
    test_byte_write();
    test_wrap();
    test_snapshot();
    test_window();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Parametrised memory-mapped RISC-V machine timer: 64-bit mtime, programmable prescaler, NUM_COMPARATORS independent 64-bit mtimecmp channels, one level interrupt per channel.
- Sits on the core's data-memory port beside block RAM; the top-level read mux selects its registered read value when read_hit is high.
- Adds multi-channel compare, prescaling, a control/status register and reset.

Parameters:
- BASE_ADDRESS, 32'h80000000, word-aligned base of the register window.
- NUM_COMPARATORS, 1, number of mtimecmp channels; range 1..8.
- PRESCALER_WIDTH, 8, width of the prescale divisor field; range 1..16.

Ports:
- clk24  input  1  core clock.
- reset_n  input  1  asynchronous, active-low reset.
- memory_address  input  32  byte address from the core.
- memory_write_value  input  32  write data, already shifted to byte lanes.
- memory_write_sections  input  4  byte-lane write enables; 0 means no write.
- read_value  output  32  registered read data, unshifted word.
- read_hit  output  1  registered; high when the previous cycle's address decoded into this block.
- timer_interrupt  output  NUM_COMPARATORS  registered per-channel level interrupt (mip.MTIP source).

Behaviour:
- Register map (byte offsets from BASE_ADDRESS; decode on address[31:2]):
  - 0x00 MTIME[31:0]
  - 0x04 MTIME[63:32]
  - 0x08 CTRL: bit0 = enable; bits [8 +: PRESCALER_WIDTH] = divisor; other bits read 0 and ignore writes.
  - 0x0C STATUS: read-only, bit i = timer_interrupt[i].
  - 0x10+8*i MTIMECMP[i] low word; 0x14+8*i MTIMECMP[i] high word.
- Addresses outside the window, or at channel offsets ≥ NUM_COMPARATORS: read_hit = 0, read_value = 0, writes ignored.
- Reset (asynchronous): mtime = 0; all mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; CTRL enable = 1, divisor = 0; prescale counter = 0; read_value = 0; read_hit = 0; timer_interrupt = 0; snapshot = 0.
- Read latency is 1 cycle. Every cycle, read_value and read_hit are updated from the current memory_address. No read strobe exists. Reads have no side effects except the snapshot below.
- Writes are byte-lane granular. Only lanes with memory_write_sections[k] = 1 are updated. Written bytes take effect the next cycle.
- Prescaler:
  - When enable = 1, the counter counts 0..divisor.
  - mtime increments by 1 on the cycle the counter equals divisor; the counter then returns to 0.
  - divisor = 0 gives one increment per cycle.
  - When enable = 0, the counter and mtime hold.
  - Writing CTRL resets the counter to 0.
- mtime wraps from 2^64-1 to 0 with no flag.
- A cycle with any nonzero write to MTIME (low or high word):
  - Written bytes load the new value; unwritten bytes keep their pre-write value.
  - No increment that cycle; the counter resets to 0.
  - A write to the low word does not carry into the high word.
- Interrupts: timer_interrupt[i] <= (mtime >= mtimecmp[i]), unsigned 64-bit compare of the current register values. The output therefore lags any mtime or mtimecmp change by 1 cycle. Writing mtimecmp[i] above mtime clears interrupt i one cycle after the write lands.
- STATUS writes are ignored.

Optional Feature:
- Macro: MACHINE_TIMER_SNAPSHOT_EN.
- With the macro defined: on every cycle where memory_address decodes to MTIME low and memory_write_sections = 0, mtime[63:32] is latched into a snapshot register. Reads of MTIME high return the snapshot. This makes low-then-high reads atomic.
- Without the macro: MTIME high reads return the live mtime[63:32], and no snapshot register exists.

Decomposition:
- Package machine_timer_pkg holds:
  - offset constants OFFSET_MTIME, OFFSET_MTIMEH, OFFSET_CTRL, OFFSET_STATUS, OFFSET_MTIMECMP_BASE and CMP_STRIDE (8);
  - CTRL bit positions;
  - the reset value of mtimecmp.
- One sub-module, timer_prescaler: divisor, enable and clear inputs; tick output.

Test Plan:
- Reset, then idle: mtime reads 0, 1, 2… on successive low-word reads; read_hit = 1 one cycle after the address is presented; timer_interrupt = 0.
- Write CTRL divisor = 3, enable = 1 → mtime advances by exactly 1 every 4 cycles; write enable = 0 → mtime frozen over 100 cycles.
- Channel 1 (NUM_COMPARATORS = 2): write mtimecmp[1] = 10 with mtime = 0 → timer_interrupt[1] rises the cycle after mtime reaches 10 and timer_interrupt[0] stays 0; rewriting mtimecmp[1] = 64'hFFFF… clears it 1 cycle later.
- Byte write: mtime = 32'h1122_3344 low word, write lane 1 = 8'hAA → low word reads 32'h1122_AA44, with no increment in that cycle.
- Wrap: load mtime = 64'hFFFF_FFFF_FFFF_FFFE, divisor = 0 → reads …FFFF, then 0; interrupts with mtimecmp = 0 stay asserted.
- With MACHINE_TIMER_SNAPSHOT_EN, mtime = 64'h0000_0001_FFFF_FFFF: read low then high while mtime carries → high returns 1, not 2. Without the macro, high returns 2.
